// File: rtl/serial_add_ctrl.sv
// Bit-serial adder controller: one full-adder cell reused WIDTH times, LSB first,
// behind a start/busy/done handshake. {cout,sum} = a + b + cin.
module serial_add_ctrl #(
   parameter  int WIDTH = 8,
   localparam int CNT_W = $clog2(WIDTH) + 1
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             start,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic             cin,
   output logic             busy,
   output logic             done,
   output logic [WIDTH-1:0] sum,
   output logic             cout
);

   typedef enum logic [1:0] {
      S_IDLE,
      S_RUN,
      S_DONE
   } state_e;

   state_e           state_q;
   logic [WIDTH-1:0] a_q;
   logic [WIDTH-1:0] b_q;
   logic [WIDTH-1:0] res_q;
   logic [WIDTH-1:0] res_d;
   logic [WIDTH-1:0] sum_q;
   logic [CNT_W-1:0] cnt_q;
   logic             carry_q;
   logic             carry_d;
   logic             s_d;
   logic             cout_q;
   logic             busy_q;
   logic             done_q;
   logic             last_bit;

   // NOTE: every signal driven here gets a value on every path, so no latch is inferred.
   always_comb begin
      s_d      = a_q[0] ^ b_q[0] ^ carry_q;
      carry_d  = (a_q[0] & b_q[0]) | (carry_q & (a_q[0] ^ b_q[0]));
      res_d    = (res_q >> 1) | (WIDTH'(s_d) << (WIDTH - 1));
      last_bit = (cnt_q == CNT_W'(WIDTH - 1));
   end

   // NOTE: all state updates use non-blocking assignments so every register samples pre-edge values.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q <= S_IDLE;
         a_q     <= '0;
         b_q     <= '0;
         res_q   <= '0;
         sum_q   <= '0;
         cnt_q   <= '0;
         carry_q <= 1'b0;
         cout_q  <= 1'b0;
         busy_q  <= 1'b0;
         done_q  <= 1'b0;
      end else begin
         case (state_q)
            S_IDLE: begin
               done_q <= 1'b0;
               if (start) begin
                  a_q     <= a;
                  b_q     <= b;
                  carry_q <= cin;
                  cnt_q   <= '0;
                  busy_q  <= 1'b1;
                  state_q <= S_RUN;
               end
            end
            S_RUN: begin
               a_q     <= a_q >> 1;
               b_q     <= b_q >> 1;
               carry_q <= carry_d;
               res_q   <= res_d;
               cnt_q   <= cnt_q + CNT_W'(1);
               // sum/cout only move here, so they hold across the next start
               if (last_bit) begin
                  sum_q   <= res_d;
                  cout_q  <= carry_d;
                  busy_q  <= 1'b0;
                  done_q  <= 1'b1;
                  state_q <= S_DONE;
               end
            end
            S_DONE: begin
               done_q  <= 1'b0;
               state_q <= S_IDLE;
            end
            default: state_q <= S_IDLE;
         endcase
      end
   end

   assign busy = busy_q;
   assign done = done_q;
   assign sum  = sum_q;
   assign cout = cout_q;

endmodule

// File: tb/tb_serial_add_ctrl.sv
// Scoreboard bench for serial_add_ctrl: an 8-bit instance for the main scenarios
// and a 1-bit instance for the degenerate full-adder build.
module tb_serial_add_ctrl;

   localparam int W8 = 8;

   logic       clk = 1'b0;
   logic       rst_n;
   logic       start8, cin8, busy8, done8, cout8;
   logic [7:0] a8, b8, sum8;
   logic       start1, cin1, busy1, done1, cout1;
   logic [0:0] a1, b1, sum1;

   int n_cmp = 0;
   int n_err = 0;

   logic [8:0] exp8_q[$];
   logic [1:0] exp1_q[$];

   serial_add_ctrl #(.WIDTH(W8)) dut8 (
      .clk(clk), .rst_n(rst_n), .start(start8), .a(a8), .b(b8), .cin(cin8),
      .busy(busy8), .done(done8), .sum(sum8), .cout(cout8)
   );

   serial_add_ctrl #(.WIDTH(1)) dut1 (
      .clk(clk), .rst_n(rst_n), .start(start1), .a(a1), .b(b1), .cin(cin1),
      .busy(busy1), .done(done1), .sum(sum1), .cout(cout1)
   );

   always #5 clk = ~clk;

   function automatic logic [8:0] pop8();
      if (exp8_q.size() == 0) return 'x;
      return exp8_q.pop_front();
   endfunction

   function automatic logic [1:0] pop1();
      if (exp1_q.size() == 0) return 'x;
      return exp1_q.pop_front();
   endfunction

   // One-cycle start pulse; returns at the first negedge after the accepting edge.
   task automatic issue8(input logic [7:0] av, input logic [7:0] bv, input logic c, input bit track);
      @(negedge clk);
      a8 = av; b8 = bv; cin8 = c; start8 = 1'b1;
      @(negedge clk);
      start8 = 1'b0;
      if (track) exp8_q.push_back({1'b0, av} + {1'b0, bv} + {8'b0, c});
   endtask

   task automatic issue1(input logic av, input logic bv, input logic c);
      @(negedge clk);
      a1 = av; b1 = bv; cin1 = c; start1 = 1'b1;
      @(negedge clk);
      start1 = 1'b0;
      exp1_q.push_back({1'b0, av} + {1'b0, bv} + {1'b0, c});
   endtask

   task automatic wait_done8(input int max_cyc, output int cyc, output int busy_cyc, output bit seen);
      cyc = 0; busy_cyc = 0; seen = 1'b0;
      while (cyc < max_cyc && !seen) begin
         @(negedge clk);
         cyc++;
         if (done8) seen = 1'b1;
         else if (busy8) busy_cyc++;
      end
   endtask

   task automatic wait_done1(input int max_cyc, output int cyc, output bit seen);
      cyc = 0; seen = 1'b0;
      while (cyc < max_cyc && !seen) begin
         @(negedge clk);
         cyc++;
         if (done1) seen = 1'b1;
      end
   endtask

   task automatic test_reset();
      rst_n = 1'b0;
      start8 = 1'b1; a8 = 8'hFF; b8 = 8'hFF; cin8 = 1'b1;
      start1 = 1'b1; a1 = 1'b1; b1 = 1'b1; cin1 = 1'b1;
      repeat (2) @(negedge clk);
      n_cmp++;
      if ({busy8, done8, cout8, sum8} !== 11'h000) begin
         n_err++;
         $display("FAIL reset_w8: got busy=%b done=%b cout=%b sum=%h, want all zero", busy8, done8, cout8, sum8);
      end
      n_cmp++;
      if ({busy1, done1, cout1, sum1} !== 4'h0) begin
         n_err++;
         $display("FAIL reset_w1: got busy=%b done=%b cout=%b sum=%b, want all zero", busy1, done1, cout1, sum1);
      end
      start8 = 1'b0; start1 = 1'b0; rst_n = 1'b1;
      @(negedge clk);
      n_cmp++;
      if (busy8 !== 1'b0 || busy1 !== 1'b0) begin
         n_err++;
         $display("FAIL reset_release: got busy8=%b busy1=%b, want 0 0", busy8, busy1);
      end
   endtask

   task automatic test_basic();
      int cyc, bcyc;
      bit seen;
      logic [8:0] e;
      issue8(8'hFF, 8'h01, 1'b0, 1'b1);
      n_cmp++;
      if (busy8 !== 1'b1) begin
         n_err++;
         $display("FAIL basic_busy: got %b want 1", busy8);
      end
      wait_done8(W8 + 4, cyc, bcyc, seen);
      n_cmp++;
      if (!seen || cyc != W8) begin
         n_err++;
         $display("FAIL basic_latency: got seen=%0d after %0d cycles, want done after %0d", seen, cyc, W8);
      end
      n_cmp++;
      if (bcyc != W8 - 1 || busy8 !== 1'b0) begin
         n_err++;
         $display("FAIL basic_busy_len: got %0d more busy cycles busy_at_done=%b, want %0d and 0", bcyc, busy8, W8 - 1);
      end
      e = pop8();
      n_cmp++;
      if ({cout8, sum8} !== e) begin
         n_err++;
         $display("FAIL basic_result: got %h want %h", {cout8, sum8}, e);
      end
      @(negedge clk);
      n_cmp++;
      if (done8 !== 1'b0 || {cout8, sum8} !== 9'h100) begin
         n_err++;
         $display("FAIL basic_hold: got done=%b result=%h, want done=0 result=100", done8, {cout8, sum8});
      end
   endtask

   task automatic test_chain();
      int cyc, bcyc;
      bit seen;
      logic [8:0] e;
      issue8(8'hA5, 8'h5A, 1'b1, 1'b1);
      wait_done8(W8 + 4, cyc, bcyc, seen);
      e = pop8();
      n_cmp++;
      if (!seen || {cout8, sum8} !== e) begin
         n_err++;
         $display("FAIL chain_first: got seen=%0d result=%h want %h", seen, {cout8, sum8}, e);
      end
      issue8(8'h12, 8'h34, 1'b0, 1'b1);
      n_cmp++;
      if (busy8 !== 1'b1 || {cout8, sum8} !== 9'h100) begin
         n_err++;
         $display("FAIL chain_accept: got busy=%b result=%h, want busy=1 held result=100", busy8, {cout8, sum8});
      end
      wait_done8(W8 + 4, cyc, bcyc, seen);
      e = pop8();
      n_cmp++;
      if (!seen || cyc != W8 || {cout8, sum8} !== e) begin
         n_err++;
         $display("FAIL chain_second: got seen=%0d cycles=%0d result=%h want %0d cycles result %h",
                  seen, cyc, {cout8, sum8}, W8, e);
      end
   endtask

   task automatic test_back_to_back();
      int cyc, bcyc;
      bit seen, acc;
      logic [8:0] e;
      @(negedge clk);
      a8 = 8'h03; b8 = 8'h04; cin8 = 1'b0; start8 = 1'b1;
      for (int op = 0; op < 3; op++) begin
         acc = 1'b0;
         for (int k = 0; k < 4 && !acc; k++) begin
            @(negedge clk);
            if (busy8) acc = 1'b1;
         end
         n_cmp++;
         if (!acc) begin
            n_err++;
            $display("FAIL b2b_accept_%0d: got no busy, want accept", op);
            break;
         end
         exp8_q.push_back(9'h007);
         a8 = 8'hFF; b8 = 8'hFF; cin8 = 1'b1;
         repeat (2) @(negedge clk);
         a8 = 8'h03; b8 = 8'h04; cin8 = 1'b0;
         wait_done8(W8 + 4, cyc, bcyc, seen);
         e = pop8();
         n_cmp++;
         if (!seen || cyc != W8 - 2 || {cout8, sum8} !== e) begin
            n_err++;
            $display("FAIL b2b_result_%0d: got seen=%0d cycles=%0d result=%h want %0d cycles result %h",
                     op, seen, cyc, {cout8, sum8}, W8 - 2, e);
         end
      end
      start8 = 1'b0;
   endtask

   task automatic test_reset_mid_run();
      int cyc, bcyc;
      bit seen;
      logic [8:0] e;
      issue8(8'h55, 8'h22, 1'b0, 1'b0);
      repeat (3) @(negedge clk);
      rst_n = 1'b0;
      @(negedge clk);
      n_cmp++;
      if ({busy8, done8, cout8, sum8} !== 11'h000) begin
         n_err++;
         $display("FAIL midrun_reset: got busy=%b done=%b cout=%b sum=%h, want all zero", busy8, done8, cout8, sum8);
      end
      rst_n = 1'b1;
      wait_done8(W8 + 4, cyc, bcyc, seen);
      n_cmp++;
      if (seen || busy8 !== 1'b0) begin
         n_err++;
         $display("FAIL midrun_no_done: got done seen=%0d busy=%b, want no done and idle", seen, busy8);
      end
      issue8(8'h80, 8'h80, 1'b1, 1'b1);
      wait_done8(W8 + 4, cyc, bcyc, seen);
      e = pop8();
      n_cmp++;
      if (!seen || cyc != W8 || {cout8, sum8} !== e) begin
         n_err++;
         $display("FAIL midrun_next_op: got seen=%0d cycles=%0d result=%h want result %h", seen, cyc, {cout8, sum8}, e);
      end
   endtask

   task automatic test_width1();
      int cyc;
      bit seen;
      logic [1:0] e;
      logic [2:0] v;
      for (int i = 0; i < 8; i++) begin
         v = 3'(i);
         issue1(v[2], v[1], v[0]);
         n_cmp++;
         if (busy1 !== 1'b1) begin
            n_err++;
            $display("FAIL w1_busy_%0d: got %b want 1", i, busy1);
         end
         wait_done1(4, cyc, seen);
         e = pop1();
         n_cmp++;
         if (!seen || cyc != 1 || {cout1, sum1} !== e) begin
            n_err++;
            $display("FAIL w1_add_%0d: got seen=%0d cycles=%0d result=%b want 1 cycle result %b",
                     i, seen, cyc, {cout1, sum1}, e);
         end
      end
   endtask

   initial begin
      test_reset();
      test_basic();
      test_chain();
      test_back_to_back();
      test_reset_mid_run();
      test_width1();
      n_cmp++;
      if (exp8_q.size() != 0 || exp1_q.size() != 0) begin
         n_err++;
         $display("FAIL scoreboard_drain: got %0d/%0d pending, want 0/0", exp8_q.size(), exp1_q.size());
      end
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
